// File: rtl/alu_dispatch_pkg.sv
// Shared instruction package: math op encoding, instruction field
// positions and the dispatch sequencing states.
package alu_dispatch_pkg;

   localparam int DATA_W = 8;
   localparam int REG_AW = 2;
   localparam int INSTR_W = 9;

   // Instruction field positions
   localparam int OP_MSB = 8;
   localparam int OP_LSB = 5;
   localparam int X_MSB  = 4;
   localparam int X_LSB  = 3;
   localparam int Y_MSB  = 2;
   localparam int Y_LSB  = 1;
   localparam int RS_BIT = 0;

   typedef enum logic [3:0] {
      MATH_ADD  = 4'd0,
      MATH_SUB  = 4'd1,
      MATH_AND  = 4'd2,
      MATH_OR   = 4'd3,
      MATH_XOR  = 4'd4,
      MATH_EQL8 = 4'd5,
      MATH_ADC  = 4'd6
   } math_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OPND = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } dispatch_state_t;

   // Bit-cast of the op field; codes outside the enum keep their raw bits.
   function automatic math_t instr_op(input logic [INSTR_W-1:0] ins);
      return math_t'(ins[OP_MSB:OP_LSB]);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x8 general register file: one write port, operand read pair plus a
// debug read port, all reads combinational.
module alu_regfile
   import alu_dispatch_pkg::*;
#(
   parameter int NREG = 4
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [REG_AW-1:0] rd_x_addr,
   input  logic [REG_AW-1:0] rd_y_addr,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] rd_x_data,
   output logic [DATA_W-1:0] rd_y_data,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] regs_r [NREG];

   // Register storage: cleared by reset, single write per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= 8'h00;
         end
      end else if (wr_en) begin
         regs_r[wr_addr] <= wr_data;
      end
   end

   assign rd_x_data = regs_r[rd_x_addr];
   assign rd_y_data = regs_r[rd_y_addr];
   assign dbg_data  = regs_r[dbg_addr];

endmodule

// File: rtl/alu_dispatch.sv
// Issue/writeback stage in front of the 8-bit ALU. Sequencing is
// IDLE -> OPND -> EXEC (EXEC_CYCLES long) -> WB; every ALU-facing output
// is registered so the latch-based ALU sees stable inputs.
// EXEC_CYCLES is legal in 1..4; NREG must be 4 (2-bit register index).
module alu_dispatch
   import alu_dispatch_pkg::*;
#(
   parameter int EXEC_CYCLES = 1,
   parameter int NREG        = 4
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   output logic               instr_ready,
   output logic               done,
   input  logic               ld_en,
   input  logic [REG_AW-1:0]  ld_addr,
   input  logic [DATA_W-1:0]  ld_data,
   input  logic [REG_AW-1:0]  dbg_addr,
   output logic [DATA_W-1:0]  dbg_data,
   output logic [DATA_W-1:0]  s_reg,
   output logic [DATA_W-1:0]  alu_x,
   output logic [DATA_W-1:0]  alu_y,
   output logic [DATA_W-1:0]  alu_m,
   output logic [3:0]         alu_op,
   output logic               alu_en,
   output logic               alu_rs,
   input  logic [DATA_W-1:0]  alu_r,
   input  logic [DATA_W-1:0]  alu_s
);

   localparam logic [2:0] EXEC_LAST = 3'(EXEC_CYCLES - 1);

   dispatch_state_t    state_r, state_s;
   logic [2:0]         cnt_r, cnt_s;
   logic [INSTR_W-1:0] instr_r;
   logic               accept_s;
   logic               instr_ready_r, done_r, alu_en_r, alu_rs_r;
   logic [DATA_W-1:0]  alu_x_r, alu_y_r, s_reg_r;
   logic [3:0]         alu_op_r;

   logic               ld_ok_s, wb_wr_s, rf_wr_en_s;
   logic [REG_AW-1:0]  rf_wr_addr_s, xi_s, yi_s;
   logic [DATA_W-1:0]  rf_wr_data_s, rd_x_s, rd_y_s;

   assign xi_s = instr_r[X_MSB:X_LSB];
   assign yi_s = instr_r[Y_MSB:Y_LSB];

   // Next-state logic and execute-cycle counting
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      accept_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (instr_ready_r && instr_valid) begin
               accept_s = 1'b1;
               state_s  = ST_OPND;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_OPND: begin
            cnt_s   = 3'd0;
            state_s = ST_EXEC;
         end
         ST_EXEC: begin
            if (cnt_r == EXEC_LAST) begin
               state_s = ST_WB;
            end else begin
               cnt_s = cnt_r + 3'd1;
            end
         end
         ST_WB: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Register-file write arbitration: WB result or external load (IDLE only)
   always_comb begin
      ld_ok_s      = ld_en && (state_r == ST_IDLE);
      wb_wr_s      = (state_r == ST_WB) && !instr_r[RS_BIT];
      rf_wr_en_s   = ld_ok_s || wb_wr_s;
      if (wb_wr_s) begin
         rf_wr_addr_s = xi_s;
         rf_wr_data_s = alu_r;
      end else begin
         rf_wr_addr_s = ld_addr;
         rf_wr_data_s = ld_data;
      end
   end

   // State register, latched instruction and registered ALU-facing outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         cnt_r         <= 3'd0;
         instr_r       <= 9'h000;
         instr_ready_r <= 1'b0;
         done_r        <= 1'b0;
         alu_en_r      <= 1'b0;
         alu_rs_r      <= 1'b0;
         alu_x_r       <= 8'h00;
         alu_y_r       <= 8'h00;
         alu_op_r      <= 4'h0;
         s_reg_r       <= 8'h00;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         instr_ready_r <= (state_s == ST_IDLE);
         done_r        <= (state_s == ST_WB);
         alu_en_r      <= (state_s == ST_EXEC);
         if (accept_s) begin
            instr_r <= instr;
         end
         if (state_r == ST_OPND) begin
            alu_x_r  <= rd_x_s;
            alu_y_r  <= rd_y_s;
            alu_op_r <= instr_op(instr_r);
            alu_rs_r <= instr_r[RS_BIT];
         end
         if ((state_r == ST_WB) && instr_r[RS_BIT]) begin
            s_reg_r <= alu_s;
         end
      end
   end

   alu_regfile #(.NREG(NREG)) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (rf_wr_en_s),
      .wr_addr   (rf_wr_addr_s),
      .wr_data   (rf_wr_data_s),
      .rd_x_addr (xi_s),
      .rd_y_addr (yi_s),
      .dbg_addr  (dbg_addr),
      .rd_x_data (rd_x_s),
      .rd_y_data (rd_y_s),
      .dbg_data  (dbg_data)
   );

   assign instr_ready = instr_ready_r;
   assign done        = done_r;
   assign alu_en      = alu_en_r;
   assign alu_rs      = alu_rs_r;
   assign alu_x       = alu_x_r;
   assign alu_y       = alu_y_r;
   assign alu_op      = alu_op_r;
   assign s_reg       = s_reg_r;
   assign alu_m       = s_reg_r;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: a stand-in ALU, a transaction-level reference
// model, a vector table, hand sequences and a randomized phase.
module tb_alu_dispatch;

   localparam int E = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       instr_valid = 1'b0;
   logic [8:0] instr = 9'h000;
   logic       instr_ready, done;
   logic       ld_en = 1'b0;
   logic [1:0] ld_addr = 2'd0;
   logic [7:0] ld_data = 8'h00;
   logic [1:0] dbg_addr = 2'd0;
   logic [7:0] dbg_data, s_reg, alu_x, alu_y, alu_m;
   logic [3:0] alu_op;
   logic       alu_en, alu_rs;
   logic [7:0] alu_r = 8'h00;
   logic [7:0] alu_s = 8'h00;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0][7:0] regs_m = '0;
   logic [7:0]      s_m = 8'h00;

   always #5 clk = ~clk;

   alu_dispatch #(.EXEC_CYCLES(E), .NREG(4)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .done(done), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .s_reg(s_reg),
      .alu_x(alu_x), .alu_y(alu_y), .alu_m(alu_m), .alu_op(alu_op), .alu_en(alu_en),
      .alu_rs(alu_rs), .alu_r(alu_r), .alu_s(alu_s)
   );

   // ALU behaviour: returns {r, s}
   function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] x,
                                          input logic [7:0] y, input logic [7:0] m);
      int t;
      case (op)
         4'd0: begin t = int'(x) + int'(y);        return {t[7:0], 7'd0, t[8]}; end
         4'd1: begin t = int'(x) - int'(y);        return {t[7:0], 7'd0, (x < y)}; end
         4'd2: return {x & y, 8'h00};
         4'd3: return {x | y, 8'h00};
         4'd4: return {x ^ y, 8'h00};
         4'd5: return {7'd0, (x == y), 7'd0, (x == y)};
         4'd6: begin t = int'(x) + int'(y) + int'(m[0]); return {t[7:0], 7'd0, t[8]}; end
         default: return 16'h0000;
      endcase
   endfunction

   // Stand-in ALU: settles its outputs on every clock it is enabled
   always @(posedge clk) begin
      if (alu_en) {alu_r, alu_s} <= alu_fn(alu_op, alu_x, alu_y, alu_m);
   end

   // Reference: one completed instruction at transaction level
   task automatic apply(input logic [8:0] ins);
      logic [15:0] rs;
      rs = alu_fn(ins[8:5], regs_m[ins[4:3]], regs_m[ins[2:1]], s_m);
      if (ins[0]) s_m = rs[7:0];
      else        regs_m[ins[4:3]] = rs[15:8];
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
      regs_m[a] = d;
   endtask

   // Reads all registers via the debug port and compares with expectations
   task automatic check_regs(input logic [3:0][7:0] e, input logic [7:0] es);
      for (int r = 0; r < 4; r++) begin
         dbg_addr = 2'(r);
         #1;
         check($sformatf("reg%0d", r), dbg_data, e[r]);
      end
      check("s_reg", s_reg, es);
      check("alu_m", alu_m, es);
      @(posedge clk); #1;
   endtask

   // Issues one instruction from IDLE and follows it through writeback
   task automatic run_instr(input logic [8:0] ins);
      int k, en_cnt;
      instr = ins; instr_valid = 1'b1;
      @(negedge clk);
      check("ready_idle", instr_ready, 1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr = 9'($urandom);
      dbg_addr = ins[4:3];
      k = 0; en_cnt = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (alu_en) en_cnt++;
         if (done) break;
      end
      check("latency", k, 2 + E);
      check("en_cycles", en_cnt, E);
      check("en_low_wb", alu_en, 0);
      check("op_out", alu_op, ins[8:5]);
      check("rs_out", alu_rs, ins[0]);
      check("x_out", alu_x, regs_m[ins[4:3]]);
      check("y_out", alu_y, regs_m[ins[2:1]]);
      check("dbg_old_wb", dbg_data, regs_m[ins[4:3]]);
      apply(ins);
      @(posedge clk); #1;
      check("done_width", done, 0);
      check("ready_back", instr_ready, 1);
   endtask

   typedef struct {
      logic [3:0][7:0] init;
      logic [8:0]      ins;
      logic [3:0][7:0] exp;
      logic [7:0]      es;
   } vec_t;

   vec_t vt[8];

   initial begin
      int k, dcnt;
      logic [8:0] ins;
      vt[0] = '{{8'h00, 8'h03, 8'h05, 8'h00}, 9'h00C, {8'h00, 8'h03, 8'h08, 8'h00}, 8'h00};
      vt[1] = '{{8'h00, 8'h05, 8'h03, 8'h00}, 9'h02C, {8'h00, 8'h05, 8'hFE, 8'h00}, 8'h00};
      vt[2] = '{{8'h5A, 8'h00, 8'h00, 8'h5A}, 9'h0A7, {8'h5A, 8'h00, 8'h00, 8'h5A}, 8'h01};
      vt[3] = '{{8'h00, 8'h00, 8'hF0, 8'h0F}, 9'h0C2, {8'h00, 8'h00, 8'hF0, 8'h00}, 8'h01};
      vt[4] = '{{8'h00, 8'h00, 8'h55, 8'hAA}, 9'h063, {8'h00, 8'h00, 8'h55, 8'hAA}, 8'h00};
      vt[5] = '{{8'h00, 8'h00, 8'h77, 8'h00}, 9'h1EA, {8'h00, 8'h00, 8'h00, 8'h00}, 8'h00};
      vt[6] = '{{8'h41, 8'h00, 8'h00, 8'h00}, 9'h01E, {8'h82, 8'h00, 8'h00, 8'h00}, 8'h00};
      vt[7] = '{{8'h00, 8'h20, 8'h00, 8'h10}, 9'h025, {8'h00, 8'h20, 8'h00, 8'h10}, 8'h01};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_en", alu_en, 0);
      check("rst_done", done, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", instr_ready, 1);
      check("rst_x", alu_x, 0);
      check("rst_op", alu_op, 0);
      check_regs('0, 8'h00);

      // Table vectors
      for (int v = 0; v < 8; v++) begin
         for (int r = 0; r < 4; r++) load(2'(r), vt[v].init[r]);
         run_instr(vt[v].ins);
         check_regs(vt[v].exp, vt[v].es);
      end

      // Back-to-back with instr_valid held high
      load(2'd1, 8'h05); load(2'd2, 8'h03);
      instr = 9'h00C; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr = 9'h02C;
      dcnt = 0;
      for (k = 1; k <= 7 + 2 * E; k++) begin
         @(negedge clk);
         if (done) dcnt++;
         check($sformatf("b2b_done_k%0d", k), done, (k == 2 + E) || (k == 5 + 2 * E));
         check($sformatf("b2b_ready_k%0d", k), instr_ready, (k == 3 + E) || (k >= 6 + 2 * E));
         if (k == 3 + E) begin
            @(posedge clk); #1;
            instr_valid = 1'b0;
         end
      end
      check("b2b_done_count", dcnt, 2);
      apply(9'h00C); apply(9'h02C);
      @(posedge clk); #1;
      check_regs(regs_m, s_m);

      // Load and accept in the same IDLE cycle; load during EXEC ignored
      instr = 9'h014; instr_valid = 1'b1;
      ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'h10;
      @(posedge clk); #1;
      instr_valid = 1'b0; ld_en = 1'b0;
      regs_m[2] = 8'h10;
      @(posedge clk); #1;
      ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'hFF;
      @(negedge clk);
      check("ld_exec_en", alu_en, 1);
      @(posedge clk); #1;
      ld_en = 1'b0;
      k = 0;
      while (k < 40 && !done) begin @(negedge clk); k++; end
      check("ld_done_seen", done, 1);
      apply(9'h014);
      @(posedge clk); #1;
      check_regs(regs_m, s_m);
      check("ld_r2", regs_m[2], 8'h20);

      // Reset during EXEC
      load(2'd1, 8'h33); load(2'd3, 8'h44);
      instr = 9'h00E; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_en_before", alu_en, 1);
      rst_n = 1'b0;
      #1;
      check("mid_en_async", alu_en, 0);
      dcnt = 0;
      repeat (2) begin @(negedge clk); if (done) dcnt++; end
      rst_n = 1'b1;
      regs_m = '0; s_m = 8'h00;
      #1;
      for (int r = 0; r < 4; r++) begin
         dbg_addr = 2'(r); #1;
         check($sformatf("mid_reg%0d", r), dbg_data, 8'h00);
      end
      @(posedge clk); #1;
      check("mid_ready", instr_ready, 1);
      repeat (3) begin @(negedge clk); if (done) dcnt++; end
      check("mid_no_done", dcnt, 0);
      @(posedge clk); #1;
      check_regs('0, 8'h00);

      // Randomized instructions against the reference model
      for (int n = 0; n < 40; n++) begin
         for (int j = 0; j < int'($urandom_range(0, 2)); j++)
            load(2'($urandom_range(0, 3)), 8'($urandom));
         ins = 9'($urandom);
         run_instr(ins);
         check_regs(regs_m, s_m);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
